// File: rtl/load_store_unit.sv
// Load/store unit: issues DMEM req/gnt/rvalid transactions and returns aligned, extended load data.
// Optional macro LSU_MISALIGN_CHK_EN traps misaligned half/word accesses without touching the bus.

module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_WAIT   = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic [3:0]            d_size_i,
    input  logic                  d_unsigned_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rd_data_o,
    output logic                  lsu_busy_o,
    output logic                  lsu_done_o,
    output logic                  bus_err_o,
    output logic                  misalign_o,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [3:0]            dmem_be_o,
    output logic [ADDR_WIDTH-1:0] dmem_addr_o,
    output logic [31:0]           dmem_wdata_o,
    input  logic                  dmem_gnt_i,
    input  logic                  dmem_rvalid_i,
    input  logic [31:0]           dmem_rdata_i
);

    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                state_q;
    logic [1:0]            off_q;
    logic [3:0]            size_q;
    logic                  uns_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  req_q;
    logic                  we_q;
    logic [3:0]            be_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rd_q;
    logic                  done_q;
    logic                  err_q;
    logic                  mis_q;

    logic                  start;
    logic                  misaligned;
    logic                  timeout_hit;
    logic [3:0]            be_next;
    logic [31:0]           wdata_next;
    logic [31:0]           load_data;

    function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                                input logic [3:0]  size,
                                                input logic        uns);
        case (size)
            4'b0001: extend_load = {{24{raw[7] & ~uns}}, raw[7:0]};
            4'b0011: extend_load = {{16{raw[15] & ~uns}}, raw[15:0]};
            default: extend_load = raw;
        endcase
    endfunction

    // An all-zero byte mask marks PIM/DMA stores that never reach this bus.
    assign start = (mem_read_i | mem_write_i) && (d_size_i != 4'b0000);

`ifdef LSU_MISALIGN_CHK_EN
    assign misaligned = ((d_size_i == 4'b0011) && addr_i[0]) ||
                        ((d_size_i == 4'b1111) && (addr_i[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign be_next     = d_size_i << addr_i[1:0];
    assign wdata_next  = wdata_i << {addr_i[1:0], 3'b000};
    assign load_data   = extend_load(dmem_rdata_i >> {off_q, 3'b000}, size_q, uns_q);
    assign timeout_hit = (MAX_WAIT != 0) && ((32'(cnt_q) + 32'd1) == 32'(MAX_WAIT));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            off_q   <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (start) begin
                        off_q  <= addr_i[1:0];
                        size_q <= d_size_i;
                        uns_q  <= d_unsigned_i;
                        if (misaligned) begin
                            mis_q   <= 1'b1;
                            rd_q    <= '0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            req_q   <= 1'b1;
                            we_q    <= mem_write_i;
                            be_q    <= be_next;
                            addr_q  <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
                            wdata_q <= wdata_next;
                            state_q <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (dmem_gnt_i) begin
                        req_q <= 1'b0;
                        if (we_q) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else if (dmem_rvalid_i) begin
                            rd_q    <= load_data;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end else if (timeout_hit) begin
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                        rd_q    <= '0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (dmem_rvalid_i) begin
                        rd_q    <= load_data;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        rd_q    <= '0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    err_q   <= 1'b0;
                    mis_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Busy rises in the request cycle itself so the pipeline stalls before the bus sees anything.
    assign lsu_busy_o   = ((state_q == S_IDLE) && start) || (state_q == S_REQ) || (state_q == S_WAIT);
    assign lsu_done_o   = done_q;
    assign rd_data_o    = rd_q;
    assign bus_err_o    = err_q;
    assign misalign_o   = mis_q;
    assign dmem_req_o   = req_q;
    assign dmem_we_o    = we_q;
    assign dmem_be_o    = be_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed accesses push expected bus and completion
// records; two negedge monitors pop and compare them whenever the DUT presents req or done.

module tb_load_store_unit;

    localparam int WINDOW = 10;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          cycles;
    } bus_exp_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        logic        mis;
        int          cyc;
    } done_exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        mem_read_i = 1'b0;
    logic        mem_write_i = 1'b0;
    logic [3:0]  d_size_i = '0;
    logic        d_unsigned_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [31:0] rd_data_o;
    logic        lsu_busy_o;
    logic        lsu_done_o;
    logic        bus_err_o;
    logic        misalign_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i = 1'b0;
    logic        dmem_rvalid_i = 1'b0;
    logic [31:0] dmem_rdata_i = '0;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int req_cycles = 0;

    bus_exp_t  exp_bus_q[$];
    done_exp_t exp_done_q[$];
    bus_exp_t  mon_b;
    done_exp_t mon_d;

    load_store_unit #(
        .ADDR_WIDTH(32),
        .MAX_WAIT  (4)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .mem_read_i   (mem_read_i),
        .mem_write_i  (mem_write_i),
        .d_size_i     (d_size_i),
        .d_unsigned_i (d_unsigned_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .rd_data_o    (rd_data_o),
        .lsu_busy_o   (lsu_busy_o),
        .lsu_done_o   (lsu_done_o),
        .bus_err_o    (bus_err_o),
        .misalign_o   (misalign_o),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_be_o    (dmem_be_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_gnt_i   (dmem_gnt_i),
        .dmem_rvalid_i(dmem_rvalid_i),
        .dmem_rdata_i (dmem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
    endtask

    task automatic finish_bus();
        check_output("req_cycles", 32'(req_cycles), 32'(mon_b.cycles));
        void'(exp_bus_q.pop_front());
        req_cycles = 0;
    endtask

    // Bus monitor: every request cycle must match the head record and stay stable until gnt.
    always @(negedge clk_i) begin
        if (dmem_req_o) begin
            if (exp_bus_q.size() == 0) begin
                check_output("unexpected_req", 32'(dmem_req_o), 32'd0);
            end else begin
                mon_b = exp_bus_q[0];
                check_output("dmem_we", 32'(dmem_we_o), 32'(mon_b.we));
                check_output("dmem_be", 32'(dmem_be_o), 32'(mon_b.be));
                check_output("dmem_addr", dmem_addr_o, mon_b.addr);
                check_output("dmem_wdata", dmem_wdata_o, mon_b.wdata);
                req_cycles++;
                if (dmem_gnt_i) finish_bus();
            end
        end else if (req_cycles > 0) begin
            finish_bus();
        end
    end

    always @(negedge clk_i) begin
        if (lsu_done_o) begin
            if (exp_done_q.size() == 0) begin
                check_output("unexpected_done", 32'(lsu_done_o), 32'd0);
            end else begin
                mon_d = exp_done_q.pop_front();
                check_output("rd_data", rd_data_o, mon_d.rd);
                check_output("bus_err", 32'(bus_err_o), 32'(mon_d.err));
                check_output("misalign", 32'(misalign_o), 32'(mon_d.mis));
                check_output("done_cycle", 32'(cyc), 32'(mon_d.cyc));
                check_output("busy_at_done", 32'(lsu_busy_o), 32'd0);
            end
        end
    end

    // One access: request for a single cycle, then k-indexed gnt/rvalid/reset pulses (k=0 is the
    // first cycle after the request edge).
    task automatic apply_stimulus(input bit wr, input logic [3:0] size, input bit uns,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] rdata, input int gnt_k, input int rvalid_k,
                                  input int rst_k, input bit exp_bus, input logic [3:0] exp_be,
                                  input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                                  input int exp_req_cycles, input bit exp_done,
                                  input logic [31:0] exp_rd, input bit exp_err, input bit exp_mis,
                                  input int exp_done_k);
        bus_exp_t  b;
        done_exp_t d;
        @(posedge clk_i);
        #1;
        mem_write_i  = wr;
        mem_read_i   = !wr;
        d_size_i     = size;
        d_unsigned_i = uns;
        addr_i       = addr;
        wdata_i      = wdata;
        if (exp_bus) begin
            b.we = wr; b.be = exp_be; b.addr = exp_addr; b.wdata = exp_wdata; b.cycles = exp_req_cycles;
            exp_bus_q.push_back(b);
        end
        if (exp_done) begin
            d.rd = exp_rd; d.err = exp_err; d.mis = exp_mis; d.cyc = cyc + 1 + exp_done_k;
            exp_done_q.push_back(d);
        end
        @(negedge clk_i);
        check_output("busy_on_request", 32'(lsu_busy_o), 32'(size != 4'b0000));
        for (int k = 0; k < WINDOW; k++) begin
            @(posedge clk_i);
            #1;
            if (k == 0) begin
                mem_read_i = 1'b0; mem_write_i = 1'b0; d_size_i = '0; d_unsigned_i = 1'b0;
                addr_i = '0; wdata_i = '0;
            end
            dmem_gnt_i    = (k == gnt_k);
            dmem_rvalid_i = (k == rvalid_k);
            dmem_rdata_i  = rdata;
            rst_i         = (k == rst_k);
        end
        @(posedge clk_i);
        #1;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; rst_i = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check_output("reset_req", 32'(dmem_req_o), 32'd0);
        check_output("reset_done", 32'(lsu_done_o), 32'd0);
        check_output("reset_busy", 32'(lsu_busy_o), 32'd0);
        check_output("reset_rd_data", rd_data_o, 32'd0);
        check_output("reset_bus_err", 32'(bus_err_o), 32'd0);
        check_output("reset_misalign", 32'(misalign_o), 32'd0);
        check_output("reset_be", 32'(dmem_be_o), 32'd0);
        check_output("reset_we", 32'(dmem_we_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // wr size uns addr wdata rdata gnt_k rv_k rst_k | bus be addr wdata req_cyc | done rd err mis done_k
        apply_stimulus(0, 4'b1111, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1, -1,
                       1, 4'b1111, 32'h100, 32'h0, 1, 1, 32'hDEADBEEF, 0, 0, 2);
        apply_stimulus(0, 4'b0001, 0, 32'h103, 32'h0, 32'h80FFFFFF, 0, 1, -1,
                       1, 4'b1000, 32'h100, 32'h0, 1, 1, 32'hFFFFFF80, 0, 0, 2);
        apply_stimulus(0, 4'b0001, 1, 32'h103, 32'h0, 32'h80FFFFFF, 0, 1, -1,
                       1, 4'b1000, 32'h100, 32'h0, 1, 1, 32'h00000080, 0, 0, 2);
        apply_stimulus(1, 4'b0011, 0, 32'h202, 32'h1234ABCD, 32'h0, 3, -1, -1,
                       1, 4'b1100, 32'h200, 32'hABCD0000, 4, 1, 32'h00000080, 0, 0, 4);
        apply_stimulus(1, 4'b1111, 0, 32'h300, 32'hCAFEF00D, 32'h0, 0, -1, -1,
                       1, 4'b1111, 32'h300, 32'hCAFEF00D, 1, 1, 32'h00000080, 0, 0, 1);
        apply_stimulus(0, 4'b0011, 0, 32'h102, 32'h0, 32'h80011234, 1, 2, -1,
                       1, 4'b1100, 32'h100, 32'h0, 2, 1, 32'hFFFF8001, 0, 0, 3);
        apply_stimulus(0, 4'b0011, 1, 32'h100, 32'h0, 32'h12349ABC, 0, 0, -1,
                       1, 4'b0011, 32'h100, 32'h0, 1, 1, 32'h00009ABC, 0, 0, 1);
        apply_stimulus(0, 4'b0001, 0, 32'h101, 32'h0, 32'h00007F00, 0, 3, -1,
                       1, 4'b0010, 32'h100, 32'h0, 1, 1, 32'h0000007F, 0, 0, 4);
        // Grant never arrives inside the budget; the late gnt/rvalid land in IDLE.
        apply_stimulus(0, 4'b1111, 0, 32'h400, 32'h0, 32'h12345678, 6, 7, -1,
                       1, 4'b1111, 32'h400, 32'h0, 4, 1, 32'h00000000, 1, 0, 4);
        apply_stimulus(0, 4'b1111, 0, 32'h700, 32'h0, 32'h0BADF00D, 0, 1, -1,
                       1, 4'b1111, 32'h700, 32'h0, 1, 1, 32'h0BADF00D, 0, 0, 2);
        // Reset while waiting for rvalid: aborted load, later rvalid ignored.
        apply_stimulus(0, 4'b1111, 0, 32'h600, 32'h0, 32'h55555555, 0, 3, 1,
                       1, 4'b1111, 32'h600, 32'h0, 1, 0, 32'h0, 0, 0, 0);
        @(negedge clk_i);
        check_output("rd_data_after_reset", rd_data_o, 32'd0);
        check_output("req_after_reset", 32'(dmem_req_o), 32'd0);
        check_output("busy_after_reset", 32'(lsu_busy_o), 32'd0);
        apply_stimulus(1, 4'b0000, 0, 32'h500, 32'hFFFFFFFF, 32'h0, 1, -1, -1,
                       0, 4'b0000, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0, 0);
`ifdef LSU_MISALIGN_CHK_EN
        apply_stimulus(0, 4'b1111, 0, 32'h101, 32'h0, 32'h11223344, 0, 0, -1,
                       0, 4'b0000, 32'h0, 32'h0, 0, 1, 32'h00000000, 0, 1, 0);
`else
        apply_stimulus(0, 4'b1111, 0, 32'h101, 32'h0, 32'h11223344, 0, 0, -1,
                       1, 4'b1110, 32'h100, 32'h0, 1, 1, 32'h00112233, 0, 0, 1);
`endif
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_output("bus_queue_drained", 32'(exp_bus_q.size()), 32'd0);
        check_output("done_queue_drained", 32'(exp_done_q.size()), 32'd0);
        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
